// File: rtl/acc_core_param.sv
// acc_core_param: parametrised single-cycle accumulator processor.
// One instruction per clock out of a host-loaded instruction memory. The
// run/halt state machine gates host access to both memories, and a
// saturating counter tracks instructions retired since the last start.
module acc_core_param #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_wdata,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] acc,
  output logic              busy,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HALT = 2'd2;

  localparam logic [2:0] OP_LOAD  = 3'd0;
  localparam logic [2:0] OP_ADD   = 3'd1;
  localparam logic [2:0] OP_STORE = 3'd2;
  localparam logic [2:0] OP_BRZ   = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd4;
  localparam logic [2:0] OP_BRN   = 3'd5;
  localparam logic [2:0] OP_AND   = 3'd6;

  logic [DATA_W-1:0]        imem [DEPTH];
  logic [DATA_W-1:0]        dmem [DEPTH];

  logic [1:0]               state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic signed [DATA_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]         ret_q, ret_d;
  logic [DATA_W-1:0]        rdata_q;

  logic [2:0]               op;
  logic [ADDR_W-1:0]        opa;
  logic signed [DATA_W-1:0] opnd;
  logic                     st_we;
  logic                     host_ok;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Fetch and operand read are combinational so an instruction completes in one edge.
  assign op      = imem[pc_q][2:0];
  assign opa     = imem[pc_q][16 +: ADDR_W];
  assign opnd    = signed'(dmem[opa]);
  assign host_ok = (state_q != S_RUN);

  // Next-state and execute logic for the run/halt machine.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    ret_d   = ret_q;
    st_we   = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          acc_d   = '0;
          ret_d   = '0;
        end
      end
      S_RUN: begin
        ret_d = sat_inc(ret_q);
        pc_d  = pc_q + ADDR_W'(1);
        case (op)
          OP_LOAD:  acc_d = opnd;
          OP_ADD:   acc_d = acc_q + opnd;
          OP_STORE: st_we = 1'b1;
          OP_BRZ:   if (acc_q == '0) pc_d = opa;
          OP_SUB:   acc_d = acc_q - opnd;
          OP_BRN:   if (acc_q[DATA_W-1]) pc_d = opa;
          OP_AND:   acc_d = acc_q & opnd;
          default: begin
            // HALT: pc parks on the HALT instruction itself
            pc_d    = pc_q;
            state_d = S_HALT;
          end
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers and the host readback register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      acc_q   <= '0;
      ret_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      ret_q   <= ret_d;
      rdata_q <= dmem[dm_addr];
    end
  end

  // Memory writes: host writes only outside RUN; no instruction executes on a reset edge.
  always_ff @(posedge clk) begin
    if (prog_we && host_ok) imem[prog_addr] <= prog_wdata;
    if (st_we && !rst) begin
      dmem[opa] <= acc_q;
    end else if (dm_we && host_ok) begin
      dmem[dm_addr] <= dm_wdata;
    end
  end

  assign dm_rdata = rdata_q;
  assign pc       = pc_q;
  assign acc      = acc_q;
  assign busy     = (state_q == S_RUN);
  assign halted   = (state_q == S_HALT);
  assign retired  = ret_q;

endmodule

// File: tb/tb_acc_core_param.sv
// Testbench for acc_core_param: directed programs plus random forward-branching
// programs, each compared cycle by cycle against an instruction-level interpreter.
module tb_acc_core_param;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = 16;
  localparam int N  = 16;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start, prog_we, dm_we;
  logic [AW-1:0] prog_addr, dm_addr, pc;
  logic [DW-1:0] prog_wdata, dm_wdata, dm_rdata, acc;
  logic          busy, halted;
  logic [CW-1:0] retired;

  acc_core_param #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .pc(pc), .acc(acc), .busy(busy), .halted(halted), .retired(retired)
  );

  // Small instance for pc wrap and counter saturation.
  logic        s_rst, s_start, s_prog_we, s_dm_we, s_busy, s_halted;
  logic [1:0]  s_prog_addr, s_dm_addr, s_pc;
  logic [17:0] s_prog_wdata, s_dm_wdata, s_dm_rdata, s_acc;
  logic [2:0]  s_retired;

  acc_core_param #(.DATA_W(18), .ADDR_W(2), .CNT_W(3)) u_small (
    .clk(clk), .rst(s_rst), .start(s_start),
    .prog_we(s_prog_we), .prog_addr(s_prog_addr), .prog_wdata(s_prog_wdata),
    .dm_we(s_dm_we), .dm_addr(s_dm_addr), .dm_wdata(s_dm_wdata), .dm_rdata(s_dm_rdata),
    .pc(s_pc), .acc(s_acc), .busy(s_busy), .halted(s_halted), .retired(s_retired)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Instruction-level reference model.
  logic [DW-1:0] m_imem [N];
  logic [DW-1:0] m_dmem [N];
  logic [AW-1:0] m_pc;
  logic [DW-1:0] m_acc;
  int            m_ret;
  bit            m_halt;

  function automatic logic [DW-1:0] ins(input int op, input int a);
    logic [DW-1:0] w;
    w = '0;
    w[2:0]   = op[2:0];
    w[19:16] = a[3:0];
    return w;
  endfunction

  task automatic model_step();
    logic [DW-1:0] w;
    int            op, a;
    int            nxt;
    w   = m_imem[m_pc];
    op  = int'(w[2:0]);
    a   = int'(w[19:16]);
    nxt = (int'(m_pc) + 1) % N;
    if (m_ret < (1 << CW) - 1) m_ret++;
    case (op)
      0: m_acc = m_dmem[a];
      1: m_acc = m_acc + m_dmem[a];
      2: m_dmem[a] = m_acc;
      3: if (m_acc == 0) nxt = a;
      4: m_acc = m_acc - m_dmem[a];
      5: if (m_acc[DW-1]) nxt = a;
      6: m_acc = m_acc & m_dmem[a];
      default: begin nxt = int'(m_pc); m_halt = 1'b1; end
    endcase
    m_pc = nxt[AW-1:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_prog(input int a, input logic [DW-1:0] w);
    prog_we = 1'b1; prog_addr = a[AW-1:0]; prog_wdata = w;
    tick();
    prog_we = 1'b0;
    m_imem[a] = w;
  endtask

  task automatic host_dm(input int a, input logic [DW-1:0] w);
    dm_we = 1'b1; dm_addr = a[AW-1:0]; dm_wdata = w;
    tick();
    dm_we = 1'b0;
    m_dmem[a] = w;
  endtask

  task automatic check_dmem();
    for (int i = 0; i < N; i++) begin
      dm_addr = i[AW-1:0];
      tick();
      check_val($sformatf("dmem%0d", i), dm_rdata, m_dmem[i]);
    end
  endtask

  // Start, then step DUT and model together. poke_at injects ignored host
  // traffic plus a start during RUN; abort_at asserts rst instead of a step.
  task automatic run(input int max_steps, input int poke_at, input int abort_at);
    int            steps;
    logic [DW-1:0] exp_rd;
    start = 1'b1;
    tick();
    start = 1'b0;
    m_pc = '0; m_acc = '0; m_ret = 0; m_halt = 1'b0;
    check_val("start_busy", busy, 1);
    steps = 0;
    while (!m_halt && steps < max_steps) begin
      if (steps == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_halted", halted, 0);
        check_val("abort_pc", pc, 0);
        check_val("abort_acc", acc, 0);
        check_val("abort_ret", retired, 0);
        check_val("abort_rd", dm_rdata, 0);
        return;
      end
      if (steps == poke_at) begin
        dm_we = 1'b1; dm_addr = 1; dm_wdata = 32'hDEAD_BEEF;
        prog_we = 1'b1; prog_addr = 1; prog_wdata = ins(7, 0);
        start = 1'b1;
      end
      exp_rd = m_dmem[dm_addr];
      tick();
      dm_we = 1'b0; prog_we = 1'b0; start = 1'b0;
      model_step();
      steps++;
      check_val($sformatf("pc@%0d", steps), pc, m_pc);
      check_val($sformatf("acc@%0d", steps), acc, m_acc);
      check_val($sformatf("ret@%0d", steps), retired, m_ret);
      check_val($sformatf("halted@%0d", steps), halted, m_halt);
      check_val($sformatf("rd@%0d", steps), dm_rdata, exp_rd);
    end
    if (!m_halt) check_val("run_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_we = 1'b0; dm_we = 1'b0;
    prog_addr = '0; dm_addr = '0; prog_wdata = '0; dm_wdata = '0;
    s_rst = 1'b1; s_start = 1'b0; s_prog_we = 1'b0; s_dm_we = 1'b0;
    s_prog_addr = '0; s_dm_addr = '0; s_prog_wdata = '0; s_dm_wdata = '0;
    tick(); tick();
    rst = 1'b0; s_rst = 1'b0;

    check_val("rst_pc", pc, 0);
    check_val("rst_acc", acc, 0);
    check_val("rst_ret", retired, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_rd", dm_rdata, 0);

    for (int i = 0; i < N; i++) begin
      host_prog(i, ins(7, 0));
      host_dm(i, DW'(i * 3));
    end

    // Add program
    host_dm(1, 5); host_dm(2, 7);
    host_prog(0, ins(0, 1)); host_prog(1, ins(1, 2));
    host_prog(2, ins(2, 3)); host_prog(3, ins(7, 0));
    run(50, -1, -1);
    check_val("add_acc", acc, 12);
    check_val("add_pc", pc, 3);
    check_val("add_ret", retired, 4);
    check_val("add_halted", halted, 1);
    dm_addr = 3; tick();
    check_val("add_dmem3", dm_rdata, 12);

    // Subtract wrap, BRZ not taken, BRN taken
    host_dm(1, 3); host_dm(2, 5);
    host_prog(0, ins(0, 1)); host_prog(1, ins(4, 2)); host_prog(2, ins(3, 5));
    host_prog(3, ins(5, 9)); host_prog(9, ins(7, 0));
    run(50, -1, -1);
    check_val("sub_acc", acc, 32'hFFFF_FFFE);
    check_val("brn_pc", pc, 9);
    check_val("brn_ret", retired, 5);

    // Countdown 3..0 with ignored host traffic mid-run
    host_dm(4, 3); host_dm(5, 1); host_dm(7, 0);
    host_prog(0, ins(0, 4)); host_prog(1, ins(4, 5)); host_prog(2, ins(2, 4));
    host_prog(3, ins(3, 6)); host_prog(4, ins(0, 7)); host_prog(5, ins(3, 0));
    host_prog(6, ins(7, 0));
    run(200, 3, -1);
    check_val("cd_ret", retired, 17);
    check_val("cd_pc", pc, 6);
    dm_addr = 4; tick();
    check_val("cd_dmem4", dm_rdata, 0);
    dm_addr = 1; tick();
    check_val("gate_dmem1", dm_rdata, 3);
    check_dmem();

    // Host write in HALTED: old value next cycle, new value the one after
    dm_we = 1'b1; dm_addr = 1; dm_wdata = 32'h1234;
    tick();
    dm_we = 1'b0;
    m_dmem[1] = 32'h1234;
    check_val("hw_prewrite", dm_rdata, 3);
    tick();
    check_val("hw_new", dm_rdata, 32'h1234);

    // rst together with start: reset wins
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check_val("rststart_busy", busy, 0);
    check_val("rststart_halted", halted, 0);

    // Reset mid-run, memory retained, rerun from pc 0
    host_dm(4, 3);
    run(200, -1, 5);
    dm_addr = 4; tick();
    check_val("abort_dmem4", dm_rdata, 2);
    check_dmem();
    run(200, -1, -1);
    check_val("rerun_ret", retired, 11);
    check_dmem();

    // prog_we and start in the same cycle: pc-0 fetch sees the new word
    prog_we = 1'b1; prog_addr = 0; prog_wdata = ins(7, 0); start = 1'b1;
    tick();
    prog_we = 1'b0; start = 1'b0;
    m_imem[0] = ins(7, 0);
    check_val("ps_busy", busy, 1);
    tick();
    check_val("ps_halted", halted, 1);
    check_val("ps_pc", pc, 0);
    check_val("ps_ret", retired, 1);

    // Random forward-branching programs terminated by HALT at the top slot
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < N; i++) begin
        logic [DW-1:0] d;
        d = $urandom;
        if ($urandom_range(0, 3) == 0) d = DW'($urandom_range(0, 2));
        host_dm(i, d);
      end
      for (int i = 0; i < N - 1; i++) begin
        logic [DW-1:0] w;
        int            op, a;
        op = $urandom_range(0, 7);
        a  = $urandom_range(0, N - 1);
        if (op == 3 || op == 5) a = $urandom_range(i + 1, N - 1);
        w = $urandom;
        w[2:0] = op[2:0];
        w[19:16] = a[3:0];
        host_prog(i, w);
      end
      begin
        logic [DW-1:0] h;
        h = $urandom;
        h[2:0] = 3'd7;
        host_prog(N - 1, h);
      end
      run(100, $urandom_range(0, 6), -1);
      check_dmem();
    end

    // Small instance: pc wraps 0..3 and counter saturates at 7
    s_dm_we = 1'b1; s_dm_addr = 0; s_dm_wdata = 18'h2A5;
    tick();
    s_dm_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_prog_we = 1'b1; s_prog_addr = i[1:0]; s_prog_wdata = 18'h0;
      tick();
    end
    s_prog_we = 1'b0;
    s_start = 1'b1;
    tick();
    s_start = 1'b0;
    check_val("s_pc0", s_pc, 0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check_val($sformatf("s_pc%0d", k), s_pc, k % 4);
      check_val($sformatf("s_ret%0d", k), s_retired, (k > 7) ? 7 : k);
      check_val($sformatf("s_acc%0d", k), s_acc, 18'h2A5);
      check_val($sformatf("s_busy%0d", k), s_busy, 1);
    end
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0;
    check_val("s_rst_busy", s_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/acc_core_param.md
# acc_core_param

Parametrised single-cycle accumulator processor: the next generation of the team's accumulator core. Data width and memory depth are parameters. The opcode space grows to eight operations, including subtract, AND, branch-on-negative and halt. The block adds a run/halt state machine, host load and readback ports for both memories, and an instruction-retired counter. It sits under a host/testbench that loads a program, pulses `start`, waits for `halted`, then reads results back.

## Interface
- `DATA_W`, 32: accumulator, data-memory word and instruction width. Must be at least `16 + ADDR_W`.
- `ADDR_W`, 4: address width. Each memory is `2**ADDR_W` words deep. Range 1..16.
- `CNT_W`, 16: width of the retired-instruction counter.
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: begin execution at pc 0. Honoured only in IDLE or HALTED.
- `prog_we`, in, 1: write `prog_wdata` to `imem[prog_addr]`.
- `prog_addr`, in, ADDR_W: instruction-memory load address.
- `prog_wdata`, in, DATA_W: instruction word to load.
- `dm_we`, in, 1: host write of `dm_wdata` to `dmem[dm_addr]`.
- `dm_addr`, in, ADDR_W: host data-memory address, used for both write and read.
- `dm_wdata`, in, DATA_W: host data word to write.
- `dm_rdata`, out, DATA_W: registered host readback of `dmem[dm_addr]`.
- `pc`, out, ADDR_W: program counter.
- `acc`, out, DATA_W: accumulator.
- `busy`, out, 1: high while in state RUN.
- `halted`, out, 1: high while in state HALTED.
- `retired`, out, CNT_W: count of instructions executed since the last start. Saturates at its maximum.

## Operation
- Instruction fields: `op = instr[2:0]`, `a = instr[16+ADDR_W-1:16]`. All other bits are ignored.
- Opcodes:
  - 0 LOAD: `acc <= dmem[a]`.
  - 1 ADD: `acc <= acc + dmem[a]`.
  - 2 STORE: `dmem[a] <= acc`.
  - 3 BRZ: if `acc == 0`, then `pc <= a`.
  - 4 SUB: `acc <= acc - dmem[a]`.
  - 5 BRN: if `acc[DATA_W-1]`, then `pc <= a`.
  - 6 AND: `acc <= acc & dmem[a]`.
  - 7 HALT: no state change except entering HALTED.
- Arithmetic: ADD and SUB wrap modulo `2**DATA_W`. There are no flags and no carry.
- Every instruction except a taken branch and HALT sets `pc <= pc + 1`. The pc wraps from `2**ADDR_W - 1` to 0.
- State machine, states IDLE, RUN, HALTED:
  - IDLE, `start` → RUN: `pc <= 0`, `acc <= 0`, `retired <= 0`.
  - RUN: execute `imem[pc]` every cycle.
  - RUN, HALT opcode → HALTED. pc stays at the address of the HALT instruction.
  - HALTED, `start` → RUN, with the same clearing as from IDLE.
  - `rst` → IDLE from any state.
- `retired` increments once per executed instruction in RUN, HALT included.
- Host ports (`prog_we`, `dm_we`) take effect only in IDLE or HALTED. In RUN they are ignored.
- `dm_rdata` is updated every cycle in every state.
- Memory contents are not reset.

## Timing
- Reset values: `pc = 0`, `acc = 0`, `retired = 0`, `busy = 0`, `halted = 0`, `dm_rdata = 0`, state IDLE.
- `start` sampled high in IDLE/HALTED:
  - `busy = 1` in the next cycle.
  - The instruction at address 0 executes on the first edge after that, so it is visible at edge 2 counting from start.
- Execution rate: one instruction per cycle. `acc`, `pc` and `dmem` are visible the cycle after the executing edge.
- HALT executing at edge N: `busy = 0` and `halted = 1` from edge N.
- `dm_rdata` has 1-cycle latency and returns the pre-write value when `dm_we` hits the same address in the same cycle.
- A STORE executing in the same cycle as a readback of the same address also returns the old value.
- Simultaneous events:
  - `rst` together with `start`: reset wins.
  - `start` during RUN: ignored.
  - `prog_we` and `start` in the same cycle: the write completes and execution begins. The pc-0 instruction is fetched a cycle later, so it sees the new word.
- `rst` mid-RUN: the next cycle is IDLE with the reset values above. Memories keep partial results.

## Test plan
- Add loop: `dmem[1] = 5`, `dmem[2] = 7`, program LOAD 1; ADD 2; STORE 3; HALT → `dmem[3] = 12`, `acc = 12`, `retired = 4`, `halted = 1`, `pc = 3`.
- Subtract wrap and branch-on-negative: LOAD of 3, SUB of 5 → `acc = 0xFFFFFFFE`. A following BRN 9 lands with `pc = 9`. BRZ on the same value is not taken and pc increments.
- Countdown: loop decrementing 3 to 0 with BRZ exit → exits after exactly 3 iterations, with `retired` matching the hand count.
- PC wrap: with `ADDR_W = 2`, fill `imem[0..3]` with LOAD 0 and no HALT → pc sequence 0,1,2,3,0. `retired` keeps counting and saturates when `CNT_W = 3`.
- Host gating: `dm_we` to address 1 during RUN → `dmem[1]` unchanged. The same write in HALTED takes effect, and readback shows the new value 2 cycles after the write request.
- Reset mid-run, then restart: assert `rst` while busy → next cycle IDLE, `acc = 0`. Memory is retained, and a new `start` reruns from pc 0.
